// File: rtl/neuron_layer_scheduler.sv
// neuron_layer_scheduler
// Sequences one shared 64-input Neuron datapath over NUM_NEURONS output
// neurons: weight fetch, fire pulse, bounded wait for the result, result
// hand-off on a valid/ready port, and a running signed argmax whose winner
// is reported after the last neuron. A missing Neuron result aborts the
// layer with a sticky Timeout_err.
// All outputs come straight from flops; the strobes are precomputed from
// the next state so they line up with the state they belong to.
module neuron_layer_scheduler #(
  parameter int NUM_NEURONS = 10,
  parameter int IDX_W       = 4,
  parameter int WGT_LAT     = 1,
  parameter int TIMEOUT     = 127,
  parameter int TO_W        = 8
) (
  input  logic             clk,
  input  logic             GlobalReset_n,
  input  logic             Start,
  output logic             Busy,
  output logic             Done,
  output logic [IDX_W-1:0] Wgt_addr,
  output logic             Wgt_rd_en,
  output logic             Neuron_Input_valid,
  input  logic             Neuron_Output_valid,
  input  logic [25:0]      Neuron_Out,
  output logic             Res_valid,
  input  logic             Res_ready,
  output logic [25:0]      Res_data,
  output logic [IDX_W-1:0] Res_idx,
  output logic [IDX_W-1:0] Class_idx,
  output logic             Class_valid,
  output logic             Timeout_err
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_FIRE   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_EMIT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // The shared counter times both the weight-read latency and the result wait.
  localparam logic [TO_W-1:0]  LAT_LAST  = TO_W'(WGT_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0]  CNT_ONE   = TO_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [25:0]      BEST_INIT = {1'b1, 25'd0};

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TO_W-1:0]    cnt_q, cnt_d;
  logic signed [25:0] best_q, best_d;
  logic signed [25:0] res_data_q, res_data_d;
  logic [IDX_W-1:0]   res_idx_q, res_idx_d;
  logic [IDX_W-1:0]   class_idx_q, class_idx_d;
  logic               class_valid_q, class_valid_d;
  logic               timeout_q, timeout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               rd_en_q, rd_en_d;
  logic               fire_q, fire_d;
  logic               res_valid_q, res_valid_d;

  // Next-state and datapath update for the layer sequencer.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    best_d        = best_q;
    res_data_d    = res_data_q;
    res_idx_d     = res_idx_q;
    class_idx_d   = class_idx_q;
    class_valid_d = class_valid_q;
    timeout_d     = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d       = S_FETCH;
          idx_d         = '0;
          cnt_d         = '0;
          best_d        = BEST_INIT;
          class_idx_d   = '0;
          class_valid_d = 1'b0;
          timeout_d     = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (cnt_q == LAT_LAST) begin
          state_d = S_FIRE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_FIRE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A result arriving on the last allowed cycle still counts.
        if (Neuron_Output_valid) begin
          res_data_d = Neuron_Out;
          res_idx_d  = idx_q;
          state_d    = S_EMIT;
        end else if (cnt_q == TO_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_FINISH;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_EMIT: begin
        if (Res_ready) begin
          // Strict compare: on a tie the earlier (lower) index is kept.
          if (res_data_q > best_q) begin
            best_d      = res_data_q;
            class_idx_d = res_idx_q;
          end else begin
            best_d = best_q;
          end
          if (idx_q == IDX_LAST) begin
            class_valid_d = 1'b1;
            state_d       = S_FINISH;
          end else begin
            idx_d   = idx_q + IDX_ONE;
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EMIT;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output strobes decoded from the upcoming state so they register in step.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_FINISH);
    rd_en_d     = (state_d == S_FETCH) && (state_q != S_FETCH);
    fire_d      = (state_d == S_FIRE);
    res_valid_d = (state_d == S_EMIT);
  end

  // State, datapath and output registers; reset returns everything to zero.
  always_ff @(posedge clk or negedge GlobalReset_n) begin
    if (!GlobalReset_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      cnt_q         <= '0;
      best_q        <= '0;
      res_data_q    <= '0;
      res_idx_q     <= '0;
      class_idx_q   <= '0;
      class_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      rd_en_q       <= 1'b0;
      fire_q        <= 1'b0;
      res_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      best_q        <= best_d;
      res_data_q    <= res_data_d;
      res_idx_q     <= res_idx_d;
      class_idx_q   <= class_idx_d;
      class_valid_q <= class_valid_d;
      timeout_q     <= timeout_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      rd_en_q       <= rd_en_d;
      fire_q        <= fire_d;
      res_valid_q   <= res_valid_d;
    end
  end

  assign Busy               = busy_q;
  assign Done               = done_q;
  assign Wgt_addr           = idx_q;
  assign Wgt_rd_en          = rd_en_q;
  assign Neuron_Input_valid = fire_q;
  assign Res_valid          = res_valid_q;
  assign Res_data           = res_data_q;
  assign Res_idx            = res_idx_q;
  assign Class_idx          = class_idx_q;
  assign Class_valid        = class_valid_q;
  assign Timeout_err        = timeout_q;

endmodule

// File: tb/tb_neuron_layer_scheduler.sv
// Scoreboard bench for neuron_layer_scheduler: a Neuron model pushes the
// expected result when it produces one, a monitor pops and compares on every
// result handshake, and the main sequence checks the per-layer argmax.
`timescale 1ns/1ps
module tb_neuron_layer_scheduler;
  localparam int NN = 10;
  localparam int IW = 4;
  localparam int TO = 127;

  logic          clk = 1'b0;
  logic          GlobalReset_n = 1'b0;
  logic          Start = 1'b0;
  logic          Neuron_Output_valid = 1'b0;
  logic [25:0]   Neuron_Out = 26'd0;
  logic          Res_ready = 1'b0;
  logic          Busy, Done, Wgt_rd_en, Neuron_Input_valid, Res_valid;
  logic          Class_valid, Timeout_err;
  logic [IW-1:0] Wgt_addr, Res_idx, Class_idx;
  logic [25:0]   Res_data;

  neuron_layer_scheduler #(.NUM_NEURONS(NN), .IDX_W(IW), .WGT_LAT(1),
                           .TIMEOUT(TO), .TO_W(8)) dut (
    .clk(clk), .GlobalReset_n(GlobalReset_n), .Start(Start), .Busy(Busy),
    .Done(Done), .Wgt_addr(Wgt_addr), .Wgt_rd_en(Wgt_rd_en),
    .Neuron_Input_valid(Neuron_Input_valid),
    .Neuron_Output_valid(Neuron_Output_valid), .Neuron_Out(Neuron_Out),
    .Res_valid(Res_valid), .Res_ready(Res_ready), .Res_data(Res_data),
    .Res_idx(Res_idx), .Class_idx(Class_idx), .Class_valid(Class_valid),
    .Timeout_err(Timeout_err));

  always #5 clk = ~clk;

  typedef struct { int d; int idx; } exp_t;
  exp_t exp_q[$];

  int checks = 0, failures = 0;
  int vals[NN];
  int lats[NN];
  int withhold = -1, ready_mode = 0, bp_n = -1, spur_en = 0;
  logic new_layer = 1'b0;
  int cyc = 0;
  int fire_cnt = 0, cur = 0, cd = 0, fire_cyc_w = 0;
  int hs_cnt = 0, rd_cnt = 0, done_cnt = 0, bp_left = 0, to_cyc = 0;
  bit to_seen = 1'b0, have_prev = 1'b0;
  int prev_d = 0, prev_i = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Neuron model: answers each fire pulse after lats[i] cycles unless withheld.
  always @(negedge clk) begin
    if (!GlobalReset_n) begin
      Neuron_Output_valid = 1'b0;
      cd = 0;
    end else begin
      Neuron_Output_valid = 1'b0;
      if (new_layer) fire_cnt = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          Neuron_Output_valid = 1'b1;
          Neuron_Out = 26'(vals[cur]);
          exp_q.push_back('{d: vals[cur], idx: cur});
        end
      end
      if (Neuron_Input_valid) begin
        cur = fire_cnt;
        if (fire_cnt == withhold) fire_cyc_w = cyc;
        else cd = lats[fire_cnt];
        fire_cnt++;
      end else if (spur_en != 0 && Wgt_rd_en) begin
        Neuron_Output_valid = 1'b1;
        Neuron_Out = 26'h2AA_AAAA;
      end
    end
  end

  // Monitor: drives Res_ready, pops the scoreboard on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!GlobalReset_n) begin
      exp_q.delete();
      Res_ready = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (new_layer) begin
        hs_cnt = 0; rd_cnt = 0; done_cnt = 0; bp_left = 5; to_seen = 1'b0;
      end else if (Timeout_err && !to_seen) begin
        to_seen = 1'b1;
        to_cyc = cyc;
      end
      if (Wgt_rd_en) rd_cnt++;
      if (Done) done_cnt++;
      if (Res_valid && hs_cnt == bp_n && bp_left > 0) begin
        Res_ready = 1'b0;
        bp_left--;
      end else if (ready_mode != 0) Res_ready = ($urandom_range(0, 3) != 0);
      else Res_ready = 1'b1;
      if (Res_valid) begin
        chk("rd_en_during_emit", int'(Wgt_rd_en), 0);
        if (have_prev) begin
          chk("res_data_stable", int'($signed(Res_data)), prev_d);
          chk("res_idx_stable", int'(Res_idx), prev_i);
        end
        if (Res_ready) begin
          if (exp_q.size() == 0) begin
            chk("scoreboard_empty_on_result", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("res_data", int'($signed(Res_data)), e.d);
            chk("res_idx", int'(Res_idx), e.idx);
          end
          hs_cnt++;
          have_prev = 1'b0;
        end else begin
          have_prev = 1'b1;
          prev_d = int'($signed(Res_data));
          prev_i = int'(Res_idx);
        end
      end else have_prev = 1'b0;
    end
  end

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(Busy), 0);
    chk({tag, "_done"}, int'(Done), 0);
    chk({tag, "_wgt_addr"}, int'(Wgt_addr), 0);
    chk({tag, "_rd_en"}, int'(Wgt_rd_en), 0);
    chk({tag, "_in_valid"}, int'(Neuron_Input_valid), 0);
    chk({tag, "_res_valid"}, int'(Res_valid), 0);
    chk({tag, "_res_data"}, int'(Res_data), 0);
    chk({tag, "_res_idx"}, int'(Res_idx), 0);
    chk({tag, "_class_idx"}, int'(Class_idx), 0);
    chk({tag, "_class_valid"}, int'(Class_valid), 0);
    chk({tag, "_timeout"}, int'(Timeout_err), 0);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1; Start = 1'b1; new_layer = 1'b1;
    @(posedge clk); #1; Start = 1'b0; new_layer = 1'b0;
  endtask

  task automatic wait_fires(input int n);
    int k;
    for (k = 0; k < 5000 && fire_cnt < n; k++) begin @(posedge clk); #1; end
    if (fire_cnt < n) chk("wait_fire_budget", fire_cnt, n);
  endtask

  task automatic run_layer(input int wh, input bit stray);
    int n_ok, best, exp_cls, k;
    bit got;
    withhold = wh;
    n_ok = (wh >= 0) ? wh : NN;
    best = -(1 << 25);
    exp_cls = 0;
    for (int i = 0; i < n_ok; i++)
      if (vals[i] > best) begin best = vals[i]; exp_cls = i; end
    pulse_start();
    chk("busy_after_start", int'(Busy), 1);
    chk("timeout_cleared", int'(Timeout_err), 0);
    chk("class_valid_cleared", int'(Class_valid), 0);
    if (stray) begin
      wait_fires(1);
      repeat (3) @(posedge clk);
      #1; Start = 1'b1;
      @(posedge clk); #1; Start = 1'b0;
    end
    got = 1'b0;
    for (k = 0; k < 20000 && !got; k++) begin
      @(posedge clk); #1;
      if (Done) got = 1'b1;
    end
    if (!got) chk("done_budget", 0, 1);
    chk("class_valid_at_done", int'(Class_valid), (wh < 0) ? 1 : 0);
    chk("timeout_at_done", int'(Timeout_err), (wh >= 0) ? 1 : 0);
    if (wh < 0) chk("class_idx", int'(Class_idx), exp_cls);
    repeat (3) @(posedge clk);
    #1;
    chk("busy_after_done", int'(Busy), 0);
    chk("done_pulses", done_cnt, 1);
    chk("rd_en_pulses", rd_cnt, (wh >= 0) ? wh + 1 : NN);
    chk("results_accepted", hs_cnt, n_ok);
    chk("scoreboard_drained", exp_q.size(), 0);
    chk("class_valid_held", int'(Class_valid), (wh < 0) ? 1 : 0);
    if (wh >= 0) chk("timeout_latency", to_cyc - fire_cyc_w, TO + 1);
  endtask

  function automatic int rnd26();
    return int'($urandom_range(0, 32'h3FF_FFFF)) - (1 << 25);
  endfunction

  task automatic rand_layer();
    for (int i = 0; i < NN; i++) begin
      vals[i] = rnd26();
      lats[i] = int'($urandom_range(1, 30));
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    GlobalReset_n = 1'b1;
    @(posedge clk); #1;
    check_zero("idle");

    // basic ascending layer
    for (int i = 0; i < NN; i++) begin vals[i] = 100 * i; lats[i] = 20; end
    run_layer(-1, 1'b0);

    // signed argmax with a tie
    vals[0] = -5; vals[1] = 7; vals[2] = 7; vals[3] = -200; vals[4] = 3;
    for (int i = 5; i < NN; i++) vals[i] = -1000 - int'($urandom_range(0, 5000));
    run_layer(-1, 1'b0);

    // all negative, smallest magnitude at index 4
    for (int i = 0; i < NN; i++) vals[i] = -int'($urandom_range(2, 1000));
    vals[4] = -1;
    run_layer(-1, 1'b0);

    // backpressure on neuron 3 plus random ready
    rand_layer();
    ready_mode = 1; bp_n = 3;
    run_layer(-1, 1'b0);
    bp_n = -1;

    // timeout on neuron 2, then a full layer with a last-cycle result
    rand_layer();
    run_layer(2, 1'b0);
    rand_layer();
    lats[7] = TO;
    run_layer(-1, 1'b0);

    // reset during WAIT of neuron 5
    rand_layer();
    for (int i = 0; i < NN; i++) lats[i] = 20;
    withhold = -1;
    pulse_start();
    wait_fires(6);
    repeat (2) @(posedge clk);
    #1; GlobalReset_n = 1'b0;
    #1; check_zero("mid_reset");
    repeat (3) begin @(posedge clk); #1; chk("no_done_in_reset", int'(Done), 0); end
    GlobalReset_n = 1'b1;

    // spurious Output_valid during FETCH and a stray Start during WAIT
    rand_layer();
    spur_en = 1;
    run_layer(-1, 1'b1);
    spur_en = 0;

    for (int r = 0; r < 3; r++) begin
      rand_layer();
      run_layer(-1, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end
endmodule
